// File: rtl/sam_mapper.sv
// SAM-style system controller: E/Q clock generator, address decoder, control register, video address counter.
// Clocks and vid_addr are registered (1 clk); decode is combinational; no backpressure, pulses act on the clk they are seen.
module sam_mapper #(
    parameter int QDIV    = 16,
    parameter int RAM_AW  = 15,
    parameter int VRAM_AW = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        cpu_addr,
    input  logic               cpu_rw,
    output logic               E,
    output logic               Q,
    output logic               e_fall,
    output logic               we,
    output logic               ram_cs,
    output logic               rom8_cs,
    output logic               romA_cs,
    output logic               romC_cs,
    output logic               pia0_cs,
    output logic               pia1_cs,
    output logic               io_cs,
    output logic               sam_cs,
    output logic [15:0]        sam_reg,
    input  logic               fs_start,
    input  logic               line_end,
    input  logic               byte_req,
    output logic [VRAM_AW-1:0] vid_addr
);
    localparam int PW = $clog2(QDIV);

    logic [PW-1:0]      r_presc;
    logic [1:0]         r_quarter;
    logic               r_e, r_q, r_efall;
    logic [15:0]        r_sam;
    logic [VRAM_AW-1:0] r_row_base, r_vid;
    logic [4:0]         r_x;
    logic [3:0]         r_ycnt;

    logic               w_qtick;
    logic [1:0]         w_qnext;
    logic               w_ty;
    logic               w_b32;
    logic [3:0]         w_ylast;
    logic [15:0]        w_fbase16;
    logic [VRAM_AW-1:0] w_fbase, w_bpr, w_row_adv, w_xoff;
    logic [4:0]         w_xnext;

    assign w_qtick = (r_presc == PW'(QDIV - 1));
    assign w_qnext = w_qtick ? r_quarter + 2'd1 : r_quarter;

    assign E       = r_e;
    assign Q       = r_q;
    assign e_fall  = r_efall;
    assign we      = ~cpu_rw & r_e;
    assign sam_reg = r_sam;
    assign vid_addr = r_vid;

    // Map type only matters when there is a full 64K of RAM behind the upper half.
    assign w_ty = (RAM_AW >= 16) && r_sam[15];

    always_comb begin
        ram_cs  = 1'b0;
        rom8_cs = 1'b0;
        romA_cs = 1'b0;
        romC_cs = 1'b0;
        pia0_cs = 1'b0;
        pia1_cs = 1'b0;
        io_cs   = 1'b0;
        sam_cs  = 1'b0;
        if (cpu_addr >= 16'hFFC0 && cpu_addr <= 16'hFFDF)
            sam_cs = 1'b1;
        else if (cpu_addr >= 16'hFF40)
            io_cs = 1'b1;
        else if (cpu_addr >= 16'hFF20)
            pia1_cs = 1'b1;
        else if (cpu_addr >= 16'hFF00)
            pia0_cs = 1'b1;
        else if (w_ty || !cpu_addr[15])
            ram_cs = 1'b1;
        else if (cpu_addr < 16'hA000)
            rom8_cs = 1'b1;
        else if (cpu_addr < 16'hC000)
            romA_cs = 1'b1;
        else
            romC_cs = 1'b1;
    end

    always_comb begin
        w_b32   = 1'b1;
        w_ylast = 4'd0;
        case (r_sam[2:0])
            3'd0: w_ylast = 4'd11;
            3'd1: begin w_b32 = 1'b0; w_ylast = 4'd2; end
            3'd2: w_ylast = 4'd2;
            3'd3: begin w_b32 = 1'b0; w_ylast = 4'd1; end
            3'd4: w_ylast = 4'd1;
            3'd5: w_b32 = 1'b0;
            default: w_ylast = 4'd0;
        endcase
    end

    assign w_fbase16 = {r_sam[9:3], 9'b0};
    assign w_fbase   = w_fbase16[VRAM_AW-1:0];
    assign w_bpr     = w_b32 ? VRAM_AW'(32) : VRAM_AW'(16);
    assign w_row_adv = r_row_base + w_bpr;
    assign w_xnext   = r_x + 5'd1;
    assign w_xoff    = w_b32 ? VRAM_AW'(w_xnext) : VRAM_AW'(w_xnext[4:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc    <= '0;
            r_quarter  <= 2'd0;
            r_e        <= 1'b0;
            r_q        <= 1'b0;
            r_efall    <= 1'b0;
            r_sam      <= 16'h0000;
            r_row_base <= '0;
            r_vid      <= '0;
            r_x        <= 5'd0;
            r_ycnt     <= 4'd0;
        end else begin
            r_presc   <= w_qtick ? '0 : r_presc + 1'b1;
            r_quarter <= w_qnext;
            r_e       <= w_qnext[1];
            r_q       <= w_qnext[1] ^ w_qnext[0];
            r_efall   <= w_qtick && (r_quarter == 2'd3);

            if (r_efall && !cpu_rw && sam_cs)
                r_sam[cpu_addr[4:1]] <= cpu_addr[0];

            // A shrunken Y divide can leave ycnt past the new limit, hence >=.
            if (fs_start) begin
                r_row_base <= w_fbase;
                r_vid      <= w_fbase;
                r_x        <= 5'd0;
                r_ycnt     <= 4'd0;
            end else if (line_end) begin
                r_x <= 5'd0;
                if (r_ycnt >= w_ylast) begin
                    r_ycnt     <= 4'd0;
                    r_row_base <= w_row_adv;
                    r_vid      <= w_row_adv;
                end else begin
                    r_ycnt <= r_ycnt + 4'd1;
                    r_vid  <= r_row_base;
                end
            end else if (byte_req) begin
                r_x   <= w_xnext;
                r_vid <= r_row_base + w_xoff;
            end
        end
    end
endmodule
